// File: rtl/mul_issue_ctrl.sv
// ----------------------------------------------------------------------------
// mul_issue_ctrl
//   Two-stage issue/retire controller around an external combinational
//   32x32 Booth/Wallace multiplier core. S1 registers the operands feeding
//   the core; S2 captures the selected 32-bit half of the product together
//   with the destination tag. Streams at 1 op/cycle with full backpressure
//   and a single-cycle flush that kills every in-flight op.
//
// Ports
//   mul_clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready       op handshake from EXE
//   in_op                   00 MUL.W, 01 MULH.W, 10 MULH.WU, 11 same as 00
//   in_a, in_b, in_dest     operands and destination tag
//   flush                   kill all in-flight ops
//   core_a, core_b          registered operands to the multiplier core
//   core_signed             signed select to the core
//   core_resetn             inverted reset to the core
//   core_result             64-bit product returned by the core
//   out_valid/out_ready     result handshake
//   out_data, out_dest      selected product half and its tag
//   busy                    any op in flight
//   perf_ops, perf_stall    performance counters (MUL_PERF_EN only)
//
// Configuration
//   MUL_PERF_EN  when defined, adds perf_ops (delivered results) and
//                perf_stall (cycles with in_valid high and in_ready low).
// ----------------------------------------------------------------------------
module mul_issue_ctrl #(
    parameter int unsigned DEST_W = 5,
    parameter int unsigned PERF_W = 32
) (
    input  logic              mul_clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              flush,
    output logic [31:0]       core_a,
    output logic [31:0]       core_b,
    output logic              core_signed,
    output logic              core_resetn,
    input  logic [63:0]       core_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic              busy
`ifdef MUL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_ops,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    logic              r_s1_valid;
    logic [31:0]       r_s1_a;
    logic [31:0]       r_s1_b;
    logic [1:0]        r_s1_op;
    logic [DEST_W-1:0] r_s1_dest;

    logic              r_s2_valid;
    logic [31:0]       r_s2_data;
    logic [DEST_W-1:0] r_s2_dest;

    logic              w_s2_allowin;
    logic              w_s1_allowin;
    logic              w_in_fire;
    logic              w_s1_to_s2;
    logic              w_sel_hi;
    logic [31:0]       w_prod_half;

    assign w_s2_allowin = !r_s2_valid || out_ready;
    assign w_s1_allowin = !r_s1_valid || w_s2_allowin;
    assign in_ready     = w_s1_allowin && !flush;
    assign w_in_fire    = in_valid && in_ready;
    assign w_s1_to_s2   = r_s1_valid && w_s2_allowin;

    // Only MULH.W and MULH.WU take the high half; reserved 11 acts as MUL.W.
    assign w_sel_hi    = (r_s1_op == 2'b01) || (r_s1_op == 2'b10);
    assign w_prod_half = w_sel_hi ? core_result[63:32] : core_result[31:0];

    assign core_a      = r_s1_a;
    assign core_b      = r_s1_b;
    assign core_signed = (r_s1_op != 2'b10);
    assign core_resetn = ~reset;

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_dest  = r_s2_dest;
    assign busy      = r_s1_valid || r_s2_valid;

    // Stage S1: operand registers feeding the core.
    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
            r_s1_dest  <= '0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_s1_valid <= 1'b1;
            end else if (w_s1_to_s2) begin
                r_s1_valid <= 1'b0;
            end
            if (w_in_fire) begin
                r_s1_a    <= in_a;
                r_s1_b    <= in_b;
                r_s1_op   <= in_op;
                r_s1_dest <= in_dest;
            end
        end
    end

    // Stage S2: captured result half; holds while out_ready is low.
    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_dest  <= '0;
        end else begin
            if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_allowin) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_to_s2) begin
                r_s2_data <= w_prod_half;
                r_s2_dest <= r_s1_dest;
            end
        end
    end

`ifdef MUL_PERF_EN
    logic [PERF_W-1:0] r_perf_ops;
    logic [PERF_W-1:0] r_perf_stall;

    // Counters ignore flush; a result handshaken during flush still counts.
    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            r_perf_ops   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_s2_valid && out_ready) begin
                r_perf_ops <= r_perf_ops + PERF_W'(1);
            end
            if (in_valid && !in_ready) begin
                r_perf_stall <= r_perf_stall + PERF_W'(1);
            end
        end
    end

    assign perf_ops   = r_perf_ops;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mul_issue_ctrl
//   Directed self-checking bench for mul_issue_ctrl. Models the combinational
//   multiplier core and checks latency, product-half selection, backpressure
//   ordering, flush, asynchronous reset and (with MUL_PERF_EN) the counters.
// ----------------------------------------------------------------------------
module tb_mul_issue_ctrl;

    logic        mul_clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_dest;
    logic        flush;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_signed;
    logic        core_resetn;
    logic [63:0] core_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_dest;
    logic        busy;
`ifdef MUL_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int          q_dest[$];
    logic [31:0] q_data[$];

    always #5 mul_clk = ~mul_clk;

    mul_issue_ctrl #(
        .DEST_W(5),
        .PERF_W(32)
    ) u_dut (
        .mul_clk    (mul_clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_dest    (in_dest),
        .flush      (flush),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_signed(core_signed),
        .core_resetn(core_resetn),
        .core_result(core_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_dest   (out_dest),
        .busy       (busy)
`ifdef MUL_PERF_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
`endif
    );

    // Core model: low 64 bits of the product of the extended operands.
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    always_comb begin
        ext_a = {{32{core_signed & core_a[31]}}, core_a};
        ext_b = {{32{core_signed & core_b[31]}}, core_b};
        core_result = ext_a * ext_b;
    end

    // Record every delivered result.
    always @(negedge mul_clk) begin
        if (!reset && out_valid && out_ready) begin
            q_dest.push_back(int'(out_dest));
            q_data.push_back(out_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge mul_clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_dest  = dest;
    endtask

    // One op with out_ready held high: accepted now, result two cycles later.
    task automatic run_single(input string tag, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] dest,
                              input logic [31:0] exp);
        out_ready = 1'b1;
        drive(op, a, b, dest);
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        #1;
        check({tag, "_t1_out_valid"}, 64'(out_valid), 64'd0);
        step();
        check({tag, "_t2_out_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(exp));
        check({tag, "_dest"}, 64'(out_dest), 64'(dest));
        step();
        check({tag, "_drained"}, 64'(busy), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_dest   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_core_resetn", 64'(core_resetn), 64'd0);
        #20;
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_core_resetn", 64'(core_resetn), 64'd1);
        step();

        // Backpressure: four ops, consumer stalls 3 cycles after first result.
        q_dest.delete();
        q_data.delete();
        out_ready = 1'b1;
        drive(2'b00, 32'd1, 32'd10, 5'd1);
        step();
        drive(2'b00, 32'd2, 32'd10, 5'd2);
        step();
        out_ready = 1'b0;
        drive(2'b00, 32'd3, 32'd10, 5'd3);
        #1;
        check("bp_first_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_data_stable", 64'(out_data), 64'd10);
            check("bp_dest_stable", 64'(out_dest), 64'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        step();
        drive(2'b00, 32'd4, 32'd10, 5'd4);
        #1;
        check("bp_op4_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("bp_count", 64'(q_dest.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_dest.size()) begin
                check("bp_order_dest", 64'(q_dest[i]), 64'(i + 1));
                check("bp_order_data", 64'(q_data[i]), 64'((i + 1) * 10));
            end
        end

        // Basic latency and MUL.W result.
        run_single("mul3x5", 2'b00, 32'h0000_0003, 32'h0000_0005, 5'd7, 32'h0000_000F);

`ifdef MUL_PERF_EN
        check("perf_ops", 64'(perf_ops), 64'd5);
        check("perf_stall", 64'(perf_stall), 64'd3);
`endif

        // Product-half selection with all-ones operands.
        run_single("ff_op01", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h0000_0000);
        run_single("ff_op10", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE);
        run_single("ff_op00", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h0000_0001);
        run_single("ff_op11", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0000_0001);

        // Flush with both stages valid; op offered during flush is dropped.
        out_ready = 1'b0;
        drive(2'b00, 32'd5, 32'd5, 5'd20);
        step();
        drive(2'b00, 32'd6, 32'd6, 5'd21);
        step();
        drive(2'b00, 32'd7, 32'd7, 5'd22);
        flush = 1'b1;
        #1;
        check("fl_busy_before", 64'(busy), 64'd1);
        check("fl_in_ready", 64'(in_ready), 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_busy", 64'(busy), 64'd0);
        check("fl_in_ready_after", 64'(in_ready), 64'd1);
        step();
        step();
        check("fl_not_accepted", 64'(busy), 64'd0);

        // Asynchronous reset mid-stream with two ops in flight.
        drive(2'b00, 32'd8, 32'd8, 5'd23);
        step();
        drive(2'b00, 32'd9, 32'd9, 5'd24);
        step();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_out_data", 64'(out_data), 64'd0);
        check("ar_out_dest", 64'(out_dest), 64'd0);
        check("ar_core_a", 64'(core_a), 64'd0);
        check("ar_core_resetn", 64'(core_resetn), 64'd0);
`ifdef MUL_PERF_EN
        check("ar_perf_ops", 64'(perf_ops), 64'd0);
`endif
        step();
        reset = 1'b0;
        #1;
        check("ar_in_ready", 64'(in_ready), 64'd1);
        run_single("ar_new", 2'b01, 32'h7FFF_FFFF, 32'h0000_0002, 5'd3, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
